// File: rtl/sparse_mac_pkg.sv
// Shared types and helpers for the sparse MAC row: controller states, default
// lane/column counts and the generic narrow-with-saturate-or-wrap arithmetic.
package sparse_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int DEF_NACT   = 2;
    localparam int DEF_COL    = 4;
    localparam int DEF_AIDX_W = $clog2(DEF_NACT);
    localparam int DEF_CIDX_W = $clog2(DEF_COL);

    // Wide operands are carried sign-extended to SAT_W; nw is the narrow width.
    localparam int SAT_W = 64;

    function automatic logic sat_overflow(input logic signed [SAT_W-1:0] v, input int nw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (nw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) || (v < lo);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_narrow(input logic signed [SAT_W-1:0] v,
                                                           input int nw,
                                                           input logic sat_en);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (nw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (!sat_en) begin
            return (v <<< (SAT_W - nw)) >>> (SAT_W - nw);
        end
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/sparse_mac_lane.sv
// One tile of the sparse row: multiplies each non-zero weight slot by its selected
// activation lane and registers the products scattered into per-column partial sums.
module sparse_mac_lane
    import sparse_mac_pkg::*;
#(
    parameter int BW     = 4,
    parameter int DEPTH  = 4,
    parameter int NACT   = DEF_NACT,
    parameter int COL    = DEF_COL,
    parameter int AIDX_W = DEF_AIDX_W,
    parameter int CIDX_W = DEF_CIDX_W,
    parameter int LSUM_W = 2 * BW + $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic [DEPTH*BW-1:0]       w_flat,
    input  logic [DEPTH*AIDX_W-1:0]   aidx_flat,
    input  logic [DEPTH*CIDX_W-1:0]   cidx_flat,
    input  logic [NACT*BW-1:0]        act_flat,
    output logic [COL*LSUM_W-1:0]     col_sum_flat
);

    logic signed [BW-1:0]     act_sel_p0 [DEPTH];
    logic signed [2*BW-1:0]   prod_p0    [DEPTH];
    logic signed [LSUM_W-1:0] col_sum_p1_d [COL];
    logic [COL-1:0][LSUM_W-1:0] col_sum_p1_q;

    always_comb begin
        for (int d = 0; d < DEPTH; d++) begin
            act_sel_p0[d] = '0;
            for (int n = 0; n < NACT; n++) begin
                if (aidx_flat[d*AIDX_W +: AIDX_W] == AIDX_W'(n)) begin
                    act_sel_p0[d] = act_flat[n*BW +: BW];
                end
            end
            prod_p0[d] = (2 * BW)'(act_sel_p0[d]) * (2 * BW)'(signed'(w_flat[d*BW +: BW]));
        end
    end

    always_comb begin
        for (int c = 0; c < COL; c++) begin
            col_sum_p1_d[c] = '0;
        end
        for (int d = 0; d < DEPTH; d++) begin
            for (int c = 0; c < COL; c++) begin
                if (cidx_flat[d*CIDX_W +: CIDX_W] == CIDX_W'(c)) begin
                    col_sum_p1_d[c] = col_sum_p1_d[c] + LSUM_W'(prod_p0[d]);
                end
            end
        end
    end

    // ---- stage 1 register: qualified by the valid flag held in the row controller
    always_ff @(posedge clk) begin
        for (int c = 0; c < COL; c++) begin
            col_sum_p1_q[c] <= col_sum_p1_d[c];
        end
    end

    assign col_sum_flat = col_sum_p1_q;

endmodule

// File: rtl/sparse_mac_row.sv
// Sparse weight-stationary MAC row: per-tile lanes feed a per-column accumulate with
// saturate/wrap, then the partial sums drain one column per valid/ready beat.
module sparse_mac_row
    import sparse_mac_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 20,
    parameter int NTILE   = 2,
    parameter int DEPTH   = 4,
    parameter int NACT    = DEF_NACT,
    parameter int COL     = DEF_COL
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cfg_sat,
    input  logic                                w_load,
    input  logic [NTILE*DEPTH*BW-1:0]           w_flat,
    input  logic [NTILE*DEPTH*$clog2(NACT)-1:0] w_aidx_flat,
    input  logic [NTILE*DEPTH*$clog2(COL)-1:0]  w_cidx_flat,
    input  logic                                psum_load,
    input  logic [COL*PSUM_BW-1:0]              in_psum_flat,
    input  logic                                start,
    input  logic                                act_valid,
    output logic                                act_ready,
    input  logic                                act_last,
    input  logic [NACT*BW-1:0]                  act_flat,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [PSUM_BW-1:0]                  out_psum,
    output logic [$clog2(COL)-1:0]              out_col,
    output logic                                out_last,
    output logic                                sat_flag,
    output logic                                busy
);

    localparam int S      = NTILE * DEPTH;
    localparam int AIDX_W = $clog2(NACT);
    localparam int CIDX_W = $clog2(COL);
    localparam int LSUM_W = 2 * BW + $clog2(DEPTH + 1);
    localparam int WIDE_W = PSUM_BW + $clog2(S + 1);

    state_e                     state_q, state_d;
    logic [S-1:0][BW-1:0]       w_q, w_d;
    logic [S-1:0][AIDX_W-1:0]   aidx_q, aidx_d;
    logic [S-1:0][CIDX_W-1:0]   cidx_q, cidx_d;
    logic [COL-1:0][PSUM_BW-1:0] acc_q, acc_d;
    logic                       vld_p1_q, vld_p1_d;
    logic                       sat_mode_q, sat_mode_d;
    logic                       sat_flag_q, sat_flag_d;
    logic [CIDX_W-1:0]          out_col_q, out_col_d;

    logic [NTILE-1:0][COL*LSUM_W-1:0] lane_sum_p1;
    logic signed [WIDE_W-1:0]   col_wide_p1 [COL];
    logic [COL-1:0]             col_ovf_p1;
    logic                       act_fire;
    logic                       out_fire;

    // ---- stage 0 -> stage 1: per-tile products scattered into column sums
    for (genvar t = 0; t < NTILE; t++) begin : g_lane
        sparse_mac_lane #(
            .BW     (BW),
            .DEPTH  (DEPTH),
            .NACT   (NACT),
            .COL    (COL),
            .AIDX_W (AIDX_W),
            .CIDX_W (CIDX_W),
            .LSUM_W (LSUM_W)
        ) u_lane (
            .clk          (clk),
            .w_flat       (w_q[t*DEPTH +: DEPTH]),
            .aidx_flat    (aidx_q[t*DEPTH +: DEPTH]),
            .cidx_flat    (cidx_q[t*DEPTH +: DEPTH]),
            .act_flat     (act_flat),
            .col_sum_flat (lane_sum_p1[t])
        );
    end

    // ---- stage 1 -> stage 2: exact column sum against the live accumulator
    always_comb begin
        for (int c = 0; c < COL; c++) begin
            col_wide_p1[c] = WIDE_W'(signed'(acc_q[c]));
            for (int t = 0; t < NTILE; t++) begin
                col_wide_p1[c] = col_wide_p1[c]
                               + WIDE_W'(signed'(lane_sum_p1[t][c*LSUM_W +: LSUM_W]));
            end
            col_ovf_p1[c] = sat_overflow(SAT_W'(col_wide_p1[c]), PSUM_BW);
        end
    end

    assign act_ready = (state_q == ST_EXEC);
    assign act_fire  = act_valid && act_ready;
    assign out_valid = (state_q == ST_DRAIN);
    assign out_last  = out_valid && (out_col_q == CIDX_W'(COL - 1));
    assign out_fire  = out_valid && out_ready;
    assign out_col   = out_col_q;
    assign out_psum  = out_valid ? acc_q[out_col_q] : '0;
    assign sat_flag  = sat_flag_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        aidx_d     = aidx_q;
        cidx_d     = cidx_q;
        acc_d      = acc_q;
        vld_p1_d   = act_fire;
        sat_mode_d = sat_mode_q;
        sat_flag_d = sat_flag_q;
        out_col_d  = out_col_q;

        case (state_q)
            ST_IDLE: begin
                if (w_load) begin
                    w_d    = w_flat;
                    aidx_d = w_aidx_flat;
                    cidx_d = w_cidx_flat;
                end
                if (psum_load) begin
                    acc_d = in_psum_flat;
                end
                if (start) begin
                    sat_mode_d = cfg_sat;
                    sat_flag_d = 1'b0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (act_fire && act_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    if (out_last) begin
                        state_d   = ST_IDLE;
                        out_col_d = '0;
                        acc_d     = '0;
                    end else begin
                        out_col_d = out_col_q + CIDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stage 2 only runs in EXEC/FLUSH, so it never collides with preload or drain clear.
        if (vld_p1_q) begin
            for (int c = 0; c < COL; c++) begin
                acc_d[c] = PSUM_BW'(sat_narrow(SAT_W'(col_wide_p1[c]), PSUM_BW, sat_mode_q));
            end
            if (|col_ovf_p1) begin
                sat_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            w_q        <= '0;
            aidx_q     <= '0;
            cidx_q     <= '0;
            acc_q      <= '0;
            vld_p1_q   <= 1'b0;
            sat_mode_q <= 1'b0;
            sat_flag_q <= 1'b0;
            out_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            aidx_q     <= aidx_d;
            cidx_q     <= cidx_d;
            acc_q      <= acc_d;
            vld_p1_q   <= vld_p1_d;
            sat_mode_q <= sat_mode_d;
            sat_flag_q <= sat_flag_d;
            out_col_q  <= out_col_d;
        end
    end

endmodule

// File: tb/tb_sparse_mac_row.sv
// Directed bench for sparse_mac_row: an integer reference model predicts every drained
// column; a per-cycle compare checks the drain stream, plus literal expectations per test.
module tb_sparse_mac_row;

    localparam int BW      = 4;
    localparam int PSUM_BW = 20;
    localparam int NTILE   = 2;
    localparam int DEPTH   = 4;
    localparam int NACT    = 2;
    localparam int COL     = 4;
    localparam int S       = NTILE * DEPTH;
    localparam int AW      = $clog2(NACT);
    localparam int CW      = $clog2(COL);
    localparam longint LIM = longint'(1) <<< (PSUM_BW - 1);

    logic                  clk;
    logic                  reset;
    logic                  cfg_sat;
    logic                  w_load;
    logic [S*BW-1:0]       w_flat;
    logic [S*AW-1:0]       w_aidx_flat;
    logic [S*CW-1:0]       w_cidx_flat;
    logic                  psum_load;
    logic [COL*PSUM_BW-1:0] in_psum_flat;
    logic                  start;
    logic                  act_valid;
    logic                  act_ready;
    logic                  act_last;
    logic [NACT*BW-1:0]    act_flat;
    logic                  out_valid;
    logic                  out_ready;
    logic [PSUM_BW-1:0]    out_psum;
    logic [CW-1:0]         out_col;
    logic                  out_last;
    logic                  sat_flag;
    logic                  busy;

    sparse_mac_row #(
        .BW(BW), .PSUM_BW(PSUM_BW), .NTILE(NTILE), .DEPTH(DEPTH), .NACT(NACT), .COL(COL)
    ) dut (
        .clk(clk), .reset(reset), .cfg_sat(cfg_sat), .w_load(w_load), .w_flat(w_flat),
        .w_aidx_flat(w_aidx_flat), .w_cidx_flat(w_cidx_flat), .psum_load(psum_load),
        .in_psum_flat(in_psum_flat), .start(start), .act_valid(act_valid),
        .act_ready(act_ready), .act_last(act_last), .act_flat(act_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
        .out_col(out_col), .out_last(out_last), .sat_flag(sat_flag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int     m_w [S];
    int     m_a [S];
    int     m_c [S];
    longint m_acc [COL];
    bit     m_sat_mode;
    bit     m_sat_flag;

    // Stimulus tables
    int     tw [S];
    int     ta [S];
    int     tc [S];
    longint tpre [COL];

    typedef struct {
        int     col;
        longint psum;
        bit     last;
        bit     sat;
    } exp_t;
    exp_t exp_q[$];

    longint got [COL];
    bit     drain_done;
    bit     prev_stall;
    longint prev_col;
    longint prev_psum;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic longint narrow_model(input longint exact, input bit sat);
        longint span;
        longint r;
        span = LIM * 2;
        if (sat) begin
            if (exact > LIM - 1) return LIM - 1;
            if (exact < -LIM) return -LIM;
            return exact;
        end
        r = exact % span;
        if (r < 0) r += span;
        if (r >= LIM) r -= span;
        return r;
    endfunction

    function automatic void model_beat(input int a0, input int a1);
        int     act [NACT];
        longint exact;
        act[0] = a0;
        act[1] = a1;
        for (int c = 0; c < COL; c++) begin
            exact = m_acc[c];
            for (int s = 0; s < S; s++) begin
                if (m_c[s] == c) exact += longint'(act[m_a[s]] * m_w[s]);
            end
            if (exact > LIM - 1 || exact < -LIM) m_sat_flag = 1'b1;
            m_acc[c] = narrow_model(exact, m_sat_mode);
        end
    endfunction

    // Per-cycle comparison of the drain port against the model's expected stream.
    task automatic cycle_compare();
        exp_t   e;
        longint ps;
        ps = longint'($signed(out_psum));
        if (reset) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("hold_valid", longint'(out_valid), 1);
            check("hold_col", longint'(out_col), prev_col);
            check("hold_psum", ps, prev_psum);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_extra: got col %0d expected no beat", out_col);
            end else begin
                e = exp_q.pop_front();
                check("drain_col", longint'(out_col), longint'(e.col));
                check("drain_psum", ps, e.psum);
                check("drain_last", longint'(out_last), longint'(e.last));
                check("drain_sat_flag", longint'(sat_flag), longint'(e.sat));
                got[out_col] = ps;
                if (out_last) drain_done = 1'b1;
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_col   = longint'(out_col);
        prev_psum  = ps;
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_compare();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_weights();
        for (int s = 0; s < S; s++) begin
            w_flat[s*BW +: BW]      = tw[s][BW-1:0];
            w_aidx_flat[s*AW +: AW] = ta[s][AW-1:0];
            w_cidx_flat[s*CW +: CW] = tc[s][CW-1:0];
        end
    endtask

    task automatic begin_run(input bit wl, input bit pl, input bit sat);
        if (wl) drive_weights();
        for (int c = 0; c < COL; c++) in_psum_flat[c*PSUM_BW +: PSUM_BW] = tpre[c][PSUM_BW-1:0];
        w_load    = wl;
        psum_load = pl;
        cfg_sat   = sat;
        start     = 1'b1;
        tick();
        w_load    = 1'b0;
        psum_load = 1'b0;
        start     = 1'b0;
        if (wl) begin
            for (int s = 0; s < S; s++) begin
                m_w[s] = tw[s];
                m_a[s] = ta[s];
                m_c[s] = tc[s];
            end
        end
        if (pl) for (int c = 0; c < COL; c++) m_acc[c] = tpre[c];
        m_sat_mode = sat;
        m_sat_flag = 1'b0;
        check("start_busy", longint'(busy), 1);
        check("start_act_ready", longint'(act_ready), 1);
        check("start_sat_clear", longint'(sat_flag), 0);
    endtask

    task automatic beat(input int a0, input int a1, input bit last);
        act_flat[0 +: BW]  = a0[BW-1:0];
        act_flat[BW +: BW] = a1[BW-1:0];
        act_valid = 1'b1;
        act_last  = last;
        check("beat_ready", longint'(act_ready), 1);
        tick();
        act_valid = 1'b0;
        act_last  = 1'b0;
        model_beat(a0, a1);
        if (last) begin
            for (int c = 0; c < COL; c++) begin
                exp_q.push_back(exp_t'{c, m_acc[c], (c == COL - 1), m_sat_flag});
                m_acc[c] = 0;
            end
        end
    endtask

    task automatic finish_drain(input int stall_col, input int stall_n);
        int stall_left;
        stall_left = stall_n;
        for (int c = 0; c < COL; c++) got[c] = -1000000;
        drain_done = 1'b0;
        check("flush_out_valid", longint'(out_valid), 0);
        check("flush_act_ready", longint'(act_ready), 0);
        out_ready = 1'b1;
        tick();
        check("first_out_valid", longint'(out_valid), 1);
        check("first_out_col", longint'(out_col), 0);
        for (int i = 0; i < 4 * COL + stall_n && !drain_done; i++) begin
            if (out_valid && int'(out_col) == stall_col && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            tick();
        end
        out_ready = 1'b1;
        if (!drain_done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got no out_last handshake expected one within budget");
        end
        check("drain_back_idle", longint'(busy), 0);
        check("drain_all_consumed", longint'(exp_q.size()), 0);
    endtask

    task automatic model_reset();
        for (int s = 0; s < S; s++) begin
            m_w[s] = 0;
            m_a[s] = 0;
            m_c[s] = 0;
        end
        for (int c = 0; c < COL; c++) m_acc[c] = 0;
        m_sat_flag = 1'b0;
        m_sat_mode = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_act_ready"}, longint'(act_ready), 0);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_out_last"}, longint'(out_last), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_out_psum"}, longint'(out_psum), 0);
        check({tag, "_sat_flag"}, longint'(sat_flag), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; cfg_sat = 1'b0; w_load = 1'b0; psum_load = 1'b0; start = 1'b0;
        w_flat = '0; w_aidx_flat = '0; w_cidx_flat = '0; in_psum_flat = '0;
        act_valid = 1'b0; act_last = 1'b0; act_flat = '0; out_ready = 1'b1;
        prev_stall = 1'b0; drain_done = 1'b0; prev_col = 0; prev_psum = 0;
        for (int c = 0; c < COL; c++) tpre[c] = 0;
        model_reset();
        tick(); tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Basic accumulate: every slot w=1 on lane 0, spread over columns s%4.
        for (int s = 0; s < S; s++) begin tw[s] = 1; ta[s] = 0; tc[s] = s % COL; end
        begin_run(1, 0, 1);
        beat(3, 0, 1);
        finish_drain(-1, 0);
        for (int c = 0; c < COL; c++) check("basic_col", got[c], 6);

        // Signed products with a bubble between beats.
        for (int s = 0; s < S; s++) begin tw[s] = 0; ta[s] = 0; tc[s] = 0; end
        tw[0] = -8; ta[0] = 1; tc[0] = 2;
        begin_run(1, 0, 1);
        beat(5, -8, 0);
        tick();
        beat(-3, -8, 0);
        beat(7, -8, 1);
        finish_drain(-1, 0);
        check("signed_col2", got[2], 192);
        check("signed_col0", got[0], 0);
        check("signed_col3", got[3], 0);
        check("signed_no_sat", longint'(sat_flag), 0);

        // Saturate vs wrap at the positive limit; w_load+psum_load+start together.
        for (int s = 0; s < S; s++) begin tw[s] = 0; ta[s] = 0; tc[s] = 0; end
        tw[0] = 1;
        tpre[0] = 524287;
        begin_run(1, 1, 1);
        beat(1, 0, 1);
        finish_drain(-1, 0);
        check("sat_col0", got[0], 524287);
        check("sat_flag_sat", longint'(sat_flag), 1);
        begin_run(0, 1, 0);
        beat(1, 0, 1);
        finish_drain(-1, 0);
        check("wrap_col0", got[0], -524288);
        check("sat_flag_wrap", longint'(sat_flag), 1);
        tpre[0] = 0;

        // Activations offered in IDLE are not consumed.
        act_valid = 1'b1;
        act_flat  = '1;
        check("idle_act_ready", longint'(act_ready), 0);
        tick();
        act_valid = 1'b0;

        // Mixed signed weights, loads during EXEC ignored, drain stalled on column 1.
        tw = '{1, -2, 3, -4, 5, -6, 7, -8};
        for (int s = 0; s < S; s++) begin ta[s] = s % 2; tc[s] = s / 2; end
        begin_run(1, 0, 1);
        for (int s = 0; s < S; s++) w_flat[s*BW +: BW] = 4'd7;
        in_psum_flat = {COL{20'd1000}};
        w_load = 1'b1;
        psum_load = 1'b1;
        tick();
        w_load = 1'b0;
        psum_load = 1'b0;
        beat(2, -3, 0);
        beat(-1, 1, 1);
        finish_drain(1, 3);
        check("mix_col0", got[0], 5);
        check("mix_col1", got[1], 11);
        check("mix_col2", got[2], 17);
        check("mix_col3", got[3], 23);

        // Reset in the middle of EXEC, then a fresh run with no carry-over.
        for (int s = 0; s < S; s++) begin tw[s] = 1; ta[s] = 0; tc[s] = s % COL; end
        begin_run(1, 0, 1);
        beat(3, 0, 0);
        beat(3, 0, 0);
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        model_reset();
        reset = 1'b0;
        tick();
        begin_run(1, 0, 0);
        beat(1, 0, 1);
        finish_drain(-1, 0);
        for (int c = 0; c < COL; c++) check("fresh_col", got[c], 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
